// File: rtl/beam_sort_top16_pkg.sv
// Shared types and defaults for the beam sorter and the codeword selector.
package beam_sort_top16_pkg;

    localparam int unsigned BEAM_DEF      = 16;
    localparam int unsigned NBEAM_IN_DEF  = 64;
    localparam int unsigned PWR_WIDTH_DEF = 32;
    localparam int unsigned IDX_WIDTH     = 8;

    typedef logic [IDX_WIDTH-1:0] beam_idx_t;

    typedef struct packed {
        logic [PWR_WIDTH_DEF-1:0] pwr;
        beam_idx_t                idx;
        logic                     vld;
    } beam_entry_t;

endpackage

// File: rtl/beam_sort_top16_if.sv
// Power-sample input stream and selected-beam list output of the beam sorter.
interface beam_sort_top16_if #(
    parameter int unsigned BEAM      = beam_sort_top16_pkg::BEAM_DEF,
    parameter int unsigned PWR_WIDTH = beam_sort_top16_pkg::PWR_WIDTH_DEF
);
    import beam_sort_top16_pkg::*;

    logic                   i_clr;
    logic                   i_pwr_valid;
    logic [PWR_WIDTH-1:0]   i_pwr_data;
    logic                   i_pwr_last;
    beam_idx_t [BEAM-1:0]   o_beam_idx;
    logic [BEAM-1:0]        o_beam_vld;
    logic                   o_rbg_load;
    logic                   o_err;

    modport master (
        output i_clr, i_pwr_valid, i_pwr_data, i_pwr_last,
        input  o_beam_idx, o_beam_vld, o_rbg_load, o_err
    );

    modport slave (
        input  i_clr, i_pwr_valid, i_pwr_data, i_pwr_last,
        output o_beam_idx, o_beam_vld, o_rbg_load, o_err
    );
endinterface

// File: rtl/beam_sort_cell.sv
// One slot of the sorted beam list: decides whether the incoming sample lands
// here or above, and takes the shifted-down, inserted or held entry.
module beam_sort_cell
    import beam_sort_top16_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        clear,
    input  logic        load,
    input  beam_entry_t above,
    input  beam_entry_t sample,
    input  logic        above_ins,
    output logic        ins_c,
    output beam_entry_t nxt_c,
    output beam_entry_t entry
);

    // Strict compare: an equal-power sample ranks below the resident entry.
    always_comb begin
        ins_c = above_ins | ~entry.vld | (entry.pwr < sample.pwr);
        nxt_c = entry;
        if (above_ins) begin
            nxt_c = above;
        end else if (ins_c) begin
            nxt_c = sample;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            entry <= '0;
        end else if (clear) begin
            entry <= '0;
        end else if (load) begin
            entry <= nxt_c;
        end
    end

endmodule

// File: rtl/beam_sort_top16.sv
// Streaming top-BEAM beam selector: insertion-sorts each RBG's beam powers and
// publishes the strongest BEAM indices when the RBG closes.
module beam_sort_top16
    import beam_sort_top16_pkg::*;
#(
    parameter int unsigned BEAM      = BEAM_DEF,
    parameter int unsigned NBEAM_IN  = NBEAM_IN_DEF,
    parameter int unsigned PWR_WIDTH = PWR_WIDTH_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    beam_sort_top16_if.slave   bus
);

    localparam int unsigned CNT_W = (NBEAM_IN > 1) ? $clog2(NBEAM_IN) : 1;

    logic [CNT_W-1:0]     cnt_q;
    logic [PWR_WIDTH-1:0] pwr_in;
    logic                 accept_c;
    logic                 close_c;
    logic                 clear_c;
    logic                 load_c;
    beam_entry_t          sample_c;
    beam_entry_t          ent_q [BEAM];
    beam_entry_t          nxt_c [BEAM];
    logic [BEAM:0]        ins_c;

    beam_idx_t [BEAM-1:0] beam_idx_q;
    logic [BEAM-1:0]      beam_vld_q;
    logic                 rbg_load_q;
    logic                 err_q;

    assign pwr_in   = bus.i_pwr_data;
    assign accept_c = bus.i_pwr_valid & ~bus.i_clr;
    assign close_c  = accept_c & (bus.i_pwr_last | (cnt_q == CNT_W'(NBEAM_IN - 1)));
    assign clear_c  = bus.i_clr | close_c;
    // Only clock the list when the sample actually lands in some slot.
    assign load_c   = accept_c & ins_c[BEAM];
    assign ins_c[0] = 1'b0;

    assign sample_c = '{pwr: PWR_WIDTH_DEF'(pwr_in), idx: IDX_WIDTH'(cnt_q), vld: 1'b1};

    for (genvar k = 0; k < BEAM; k++) begin : g_cell
        beam_entry_t above_c;
        if (k == 0) begin : g_head
            assign above_c = '0;
        end else begin : g_body
            assign above_c = ent_q[k-1];
        end

        beam_sort_cell u_cell (
            .i_clk     (i_clk),
            .i_reset_n (i_reset_n),
            .clear     (clear_c),
            .load      (load_c),
            .above     (above_c),
            .sample    (sample_c),
            .above_ins (ins_c[k]),
            .ins_c     (ins_c[k+1]),
            .nxt_c     (nxt_c[k]),
            .entry     (ent_q[k])
        );
    end

    // Snapshot of the list including the closing sample; empty slots read as index 0.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q      <= '0;
            beam_idx_q <= '0;
            beam_vld_q <= '0;
            rbg_load_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            rbg_load_q <= close_c;
            err_q      <= close_c & ~bus.i_pwr_last;
            if (clear_c) begin
                cnt_q <= '0;
            end else if (accept_c) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (close_c) begin
                for (int k = 0; k < int'(BEAM); k++) begin
                    beam_idx_q[k] <= nxt_c[k].vld ? nxt_c[k].idx : '0;
                    beam_vld_q[k] <= nxt_c[k].vld;
                end
            end
        end
    end

    assign bus.o_beam_idx = beam_idx_q;
    assign bus.o_beam_vld = beam_vld_q;
    assign bus.o_rbg_load = rbg_load_q;
    assign bus.o_err      = err_q;

endmodule

// File: tb/tb_beam_sort_top16.sv
// Self-checking bench for beam_sort_top16 against a sort-and-select reference model.
module tb_beam_sort_top16;

    localparam int unsigned BEAM = 16;
    localparam int unsigned NIN  = 64;

    logic clk;
    logic rst_n;

    beam_sort_top16_if bus ();

    beam_sort_top16 dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: powers of the open RBG (position = index) and expected outputs.
    int unsigned              mq[$];
    logic [BEAM-1:0][7:0]     exp_idx = '0;
    logic [BEAM-1:0]          exp_vld = '0;
    logic                     exp_load = 1'b0;
    logic                     exp_err = 1'b0;

    // Pick strongest remaining beam per slot; strict '>' scanning upward keeps the lower index on ties.
    function automatic void model_close();
        bit used [NIN];
        int best;
        for (int i = 0; i < int'(NIN); i++) used[i] = 1'b0;
        for (int s = 0; s < int'(BEAM); s++) begin
            best = -1;
            for (int i = 0; i < mq.size(); i++) begin
                if (!used[i] && (best < 0 || mq[i] > mq[best])) best = i;
            end
            if (best >= 0) begin
                exp_idx[s] = 8'(best);
                exp_vld[s] = 1'b1;
                used[best] = 1'b1;
            end else begin
                exp_idx[s] = 8'd0;
                exp_vld[s] = 1'b0;
            end
        end
    endfunction

    task automatic step(input logic v, input int unsigned p, input logic l, input logic c);
        bus.i_pwr_valid = v;
        bus.i_pwr_data  = p;
        bus.i_pwr_last  = l;
        bus.i_clr       = c;
        @(posedge clk);
        exp_load = 1'b0;
        exp_err  = 1'b0;
        if (c) begin
            mq.delete();
        end else if (v) begin
            mq.push_back(p);
            if (l || mq.size() == int'(NIN)) begin
                model_close();
                exp_load = 1'b1;
                exp_err  = ~l;
                mq.delete();
            end
        end
        @(negedge clk);
        checks += 4;
        if (bus.o_rbg_load !== exp_load) begin
            errors++;
            $display("FAIL rbg_load t=%0t: got %0b want %0b", $time, bus.o_rbg_load, exp_load);
        end
        if (bus.o_err !== exp_err) begin
            errors++;
            $display("FAIL err t=%0t: got %0b want %0b", $time, bus.o_err, exp_err);
        end
        if (bus.o_beam_vld !== exp_vld) begin
            errors++;
            $display("FAIL beam_vld t=%0t: got %h want %h", $time, bus.o_beam_vld, exp_vld);
        end
        if (bus.o_beam_idx !== exp_idx) begin
            errors++;
            $display("FAIL beam_idx t=%0t: got %h want %h", $time, bus.o_beam_idx, exp_idx);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_pwr_valid = 1'b0;
        bus.i_pwr_data  = '0;
        bus.i_pwr_last  = 1'b0;
        bus.i_clr       = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (bus.o_rbg_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %0b want 0", bus.o_rbg_load); end
        if (bus.o_err !== 1'b0)      begin errors++; $display("FAIL reset_err: got %0b want 0", bus.o_err); end
        if (bus.o_beam_vld !== '0)   begin errors++; $display("FAIL reset_vld: got %h want 0", bus.o_beam_vld); end
        if (bus.o_beam_idx !== '0)   begin errors++; $display("FAIL reset_idx: got %h want 0", bus.o_beam_idx); end
        rst_n = 1'b1;
    endtask

    task automatic test_ascending();
        logic [BEAM-1:0][7:0] e;
        for (int i = 0; i < int'(NIN); i++) step(1'b1, i, i == int'(NIN) - 1, 1'b0);
        for (int s = 0; s < int'(BEAM); s++) e[s] = 8'(63 - s);
        checks += 3;
        if (bus.o_beam_idx !== e)       begin errors++; $display("FAIL asc_idx: got %h want %h", bus.o_beam_idx, e); end
        if (bus.o_beam_vld !== 16'hFFFF) begin errors++; $display("FAIL asc_vld: got %h want ffff", bus.o_beam_vld); end
        if (bus.o_err !== 1'b0)          begin errors++; $display("FAIL asc_err: got %0b want 0", bus.o_err); end
    endtask

    task automatic test_descending();
        logic [BEAM-1:0][7:0] e;
        for (int i = 0; i < int'(NIN); i++) step(1'b1, 63 - i, i == int'(NIN) - 1, 1'b0);
        for (int s = 0; s < int'(BEAM); s++) e[s] = 8'(s);
        checks += 1;
        if (bus.o_beam_idx !== e) begin errors++; $display("FAIL desc_idx: got %h want %h", bus.o_beam_idx, e); end
    endtask

    task automatic test_ties();
        logic [BEAM-1:0][7:0] e;
        for (int i = 0; i < int'(NIN); i++) step(1'b1, 100, i == int'(NIN) - 1, 1'b0);
        for (int s = 0; s < int'(BEAM); s++) e[s] = 8'(s);
        checks += 1;
        if (bus.o_beam_idx !== e) begin errors++; $display("FAIL tie_idx: got %h want %h", bus.o_beam_idx, e); end
    endtask

    task automatic test_short_rbg();
        logic [BEAM-1:0][7:0] e;
        idle(2);
        for (int i = 0; i < 10; i++) step(1'b1, i + 1, i == 9, 1'b0);
        e = '0;
        for (int s = 0; s < 10; s++) e[s] = 8'(9 - s);
        checks += 3;
        if (bus.o_rbg_load !== 1'b1)     begin errors++; $display("FAIL short_load: got %0b want 1", bus.o_rbg_load); end
        if (bus.o_beam_vld !== 16'h03FF) begin errors++; $display("FAIL short_vld: got %h want 03ff", bus.o_beam_vld); end
        if (bus.o_beam_idx !== e)        begin errors++; $display("FAIL short_idx: got %h want %h", bus.o_beam_idx, e); end
        idle(3);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < int'(NIN); i++) step(1'b1, $urandom(), 1'b0, 1'b0);
        checks += 2;
        if (bus.o_rbg_load !== 1'b1) begin errors++; $display("FAIL implicit_load: got %0b want 1", bus.o_rbg_load); end
        if (bus.o_err !== 1'b1)      begin errors++; $display("FAIL implicit_err: got %0b want 1", bus.o_err); end
        for (int i = 0; i < 20; i++) step(1'b1, $urandom_range(0, 15), i == 19, 1'b0);
        idle(2);
    endtask

    task automatic test_clr();
        logic [BEAM-1:0][7:0] e;
        int unsigned pw [5] = '{50, 40, 30, 20, 10};
        for (int i = 0; i < 5; i++) step(1'b1, pw[i], i == 4, 1'b0);
        for (int i = 0; i < 29; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        e = '0;
        for (int s = 0; s < 5; s++) e[s] = 8'(s);
        checks += 3;
        if (bus.o_rbg_load !== 1'b0)     begin errors++; $display("FAIL clr_load: got %0b want 0", bus.o_rbg_load); end
        if (bus.o_beam_vld !== 16'h001F) begin errors++; $display("FAIL clr_vld: got %h want 001f", bus.o_beam_vld); end
        if (bus.o_beam_idx !== e)        begin errors++; $display("FAIL clr_idx: got %h want %h", bus.o_beam_idx, e); end
        idle(2);
        for (int i = 0; i < int'(NIN); i++) step(1'b1, $urandom_range(0, 40), i == int'(NIN) - 1, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20; i++) step(1'b1, $urandom(), 1'b0, 1'b0);
        bus.i_pwr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.o_rbg_load !== 1'b0) begin errors++; $display("FAIL mid_rst_load: got %0b want 0", bus.o_rbg_load); end
        if (bus.o_err !== 1'b0)      begin errors++; $display("FAIL mid_rst_err: got %0b want 0", bus.o_err); end
        if (bus.o_beam_vld !== '0)   begin errors++; $display("FAIL mid_rst_vld: got %h want 0", bus.o_beam_vld); end
        if (bus.o_beam_idx !== '0)   begin errors++; $display("FAIL mid_rst_idx: got %h want 0", bus.o_beam_idx); end
        mq.delete();
        exp_idx = '0;
        exp_vld = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(NIN); i++) step(1'b1, $urandom(), i == int'(NIN) - 1, 1'b0);
    endtask

    task automatic test_random();
        logic v;
        logic l;
        logic c;
        int unsigned p;
        for (int n = 0; n < 600; n++) begin
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 23) == 0);
            c = ($urandom_range(0, 79) == 0);
            p = (n < 300) ? $urandom_range(0, 15) : $urandom();
            step(v, p, l, c);
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_ties();
        test_short_rbg();
        test_back_to_back();
        test_clr();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/beam_sort_top16.md
BEAM_SORT_TOP16 -- requirements
Module: beam_sort_top16

Interface
REQ-001 Parameter BEAM, default 16: number of selected beams, which is the output list depth.
REQ-002 Parameter NBEAM_IN, default 64: candidate beams per RBG; indices run 0..NBEAM_IN-1.
REQ-003 Parameter PWR_WIDTH, default 32: unsigned power width.
REQ-004 i_clk  in  1  sole clock.
REQ-005 i_reset_n  in  1  asynchronous active-low reset.
REQ-006 i_clr  in  1  synchronous abort; discards the RBG currently being accumulated.
REQ-007 i_pwr_valid  in  1  power sample qualifier.
REQ-008 i_pwr_data  in  PWR_WIDTH  unsigned beam power.
REQ-009 i_pwr_last  in  1  last sample of the RBG; qualified by i_pwr_valid.
REQ-010 o_beam_idx  out  [BEAM-1:0][7:0]  selected beam indices, slot 0 = strongest.
REQ-011 o_beam_vld  out  BEAM  per-slot occupancy of o_beam_idx.
REQ-012 o_rbg_load  out  1  one-cycle pulse when o_beam_idx/o_beam_vld update; drives the codeword selector's i_rbg_load.
REQ-013 o_err  out  1  one-cycle pulse on an implicit RBG close (REQ-021).

Function
REQ-014 The block SHALL hold an internal candidate index counter cnt, 0..NBEAM_IN-1, and tag each accepted sample with index cnt.
- cnt increments per accepted sample.
- cnt returns to 0 on RBG close or i_clr.
REQ-015 The block SHALL keep a working list of BEAM entries {pwr, idx, vld}, sorted in descending pwr, with invalid entries ranked below all valid ones.
REQ-016 Each accepted sample SHALL be inserted at the first slot k where the entry is invalid or entry.pwr < sample, all in one cycle.
- Slots k..BEAM-2 shift down one slot.
- Slot BEAM-1 is dropped.
- If no such k exists, the sample is discarded.
REQ-017 On equal power the earlier (lower) index SHALL keep the higher rank, because the comparison is strict.
REQ-018 RBG close SHALL occur on an accepted sample with i_pwr_last=1, or with cnt==NBEAM_IN-1.
- The list including that sample is registered into o_beam_idx/o_beam_vld.
- o_rbg_load is asserted in the following cycle (latency 1 from the closing sample).
REQ-019 In the close cycle the working list SHALL be cleared, so a new RBG's first sample is accepted in the very next cycle with no bubble.
REQ-020 On a short RBG, unoccupied slots SHALL output o_beam_idx=8'd0 with o_beam_vld bit=0.
REQ-021 If cnt==NBEAM_IN-1 and i_pwr_last=0, the RBG SHALL close normally and o_err SHALL pulse together with o_rbg_load.
REQ-022 i_clr SHALL take priority over i_pwr_valid in the same cycle.
- The coincident sample is dropped.
- The list and cnt are cleared.
- No o_rbg_load is produced.
- o_beam_idx/o_beam_vld hold their previous values.
REQ-023 o_beam_idx and o_beam_vld SHALL change only on close and SHALL be stable between o_rbg_load pulses.
REQ-024 i_pwr_last with i_pwr_valid=0 SHALL be ignored.

Reset
REQ-025 While i_reset_n=0 the following SHALL be asynchronously zeroed: o_beam_idx, o_beam_vld, o_rbg_load, o_err, cnt, and all working-list entries (vld=0).
REQ-026 Reset release SHALL be synchronized to i_clk.
- The first sample is accepted on the first rising edge after release.
- A partially accumulated RBG is lost with no output.

Structure
REQ-027 The shared package SHALL hold:
- BEAM, NBEAM_IN, PWR_WIDTH defaults;
- the list entry struct {pwr, idx[7:0], vld};
- the 8-bit beam index typedef, shared with the codeword selector.
REQ-028 One sub-module, beam_sort_cell, SHALL implement one list slot.
- Inputs: the neighbour-above entry, the incoming sample, and the above-slot's "insert-here-or-above" flag.
- It generates its own flag and next entry.
- It is instantiated BEAM times in a chain.

Verification
REQ-029 Powers 0..63 ascending, last on idx 63 -> one cycle later o_rbg_load=1, o_beam_idx[0..15]=63..48, o_beam_vld=16'hFFFF, o_err=0.
REQ-030 Powers 63..0 descending, last on idx 63 -> o_beam_idx[0..15]=0..15.
REQ-031 All powers equal 100 -> o_beam_idx[0..15]=0..15 (tie rule).
REQ-032 10 samples (powers 1..10), last on the 10th -> o_beam_vld=16'h03FF, slots 0..9 = idx 9..0, slots 10..15 = 0.
REQ-033 64 samples with no last -> o_rbg_load and o_err pulse together; a back-to-back second RBG starting the next cycle yields a correct, independent result.
REQ-034 i_clr asserted at sample 30 -> no o_rbg_load and outputs unchanged; i_reset_n low mid-RBG -> all outputs 0 immediately and the next full RBG is correct.
